// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I execute stage: ALUOp selects, ALU operations,
// writeback selects, opcodes used by EX, and branch funct3 values.
package rv_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10
  } mem2reg_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_hazard_if.sv
// ID/EX inputs, forwarding feedback, redirect outputs and EX/MEM register
// outputs of the execute stage, bundled as one interface.
interface ex_hazard_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] read_data1_IDEX, read_data2_IDEX;
  logic [XLEN-1:0] PC_IDEX, PC_plus4_IDEX, imm_IDEX;
  logic [31:0]     instruc_IDEX;
  logic [4:0]      rd_IDEX;
  logic            branch_IDEX, memRead_IDEX, memWrite_IDEX;
  logic            ALUSrc_IDEX, RegWrite_IDEX, jump_IDEX;
  logic [1:0]      mem2reg_IDEX, ALUOp_IDEX;
  logic [XLEN-1:0] alu_result_EXMEM_fb;
  logic [4:0]      rd_EXMEM_fb;
  logic            RegWrite_EXMEM_fb;
  logic [XLEN-1:0] write_Data;
  logic [4:0]      rd;
  logic            RegWrite;
  logic            pc_sel, flush_IF, flush_ID;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] alu_result_EXMEM, store_data_EXMEM, PC_plus4_EXMEM;
  logic [4:0]      rd_EXMEM;
  logic [2:0]      funct3_EXMEM;
  logic            memRead_EXMEM, memWrite_EXMEM, RegWrite_EXMEM;
  logic [1:0]      mem2reg_EXMEM;

  modport master (
    output read_data1_IDEX, read_data2_IDEX, PC_IDEX, PC_plus4_IDEX, imm_IDEX,
           instruc_IDEX, rd_IDEX, branch_IDEX, memRead_IDEX, memWrite_IDEX,
           ALUSrc_IDEX, RegWrite_IDEX, jump_IDEX, mem2reg_IDEX, ALUOp_IDEX,
           alu_result_EXMEM_fb, rd_EXMEM_fb, RegWrite_EXMEM_fb,
           write_Data, rd, RegWrite,
    input  pc_sel, flush_IF, flush_ID, pc_target,
           alu_result_EXMEM, store_data_EXMEM, PC_plus4_EXMEM, rd_EXMEM,
           funct3_EXMEM, memRead_EXMEM, memWrite_EXMEM, RegWrite_EXMEM,
           mem2reg_EXMEM
  );

  modport slave (
    input  read_data1_IDEX, read_data2_IDEX, PC_IDEX, PC_plus4_IDEX, imm_IDEX,
           instruc_IDEX, rd_IDEX, branch_IDEX, memRead_IDEX, memWrite_IDEX,
           ALUSrc_IDEX, RegWrite_IDEX, jump_IDEX, mem2reg_IDEX, ALUOp_IDEX,
           alu_result_EXMEM_fb, rd_EXMEM_fb, RegWrite_EXMEM_fb,
           write_Data, rd, RegWrite,
    output pc_sel, flush_IF, flush_ID, pc_target,
           alu_result_EXMEM, store_data_EXMEM, PC_plus4_EXMEM, rd_EXMEM,
           funct3_EXMEM, memRead_EXMEM, memWrite_EXMEM, RegWrite_EXMEM,
           mem2reg_EXMEM
  );
endinterface

// File: rtl/alu_control_alu.sv
// ALU control decode (ALUOp + funct3 + instruction bit 30) and the
// combinational RV32I integer ALU.
module alu_control_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  alu_op_e    op;
  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    op = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:    op = ALU_ADD;
      ALUOP_BRANCH: op = ALU_SUB;
      default: begin
        case (funct3)
          // bit 30 means SUB only for register-register ops; I-type has no SUBI
          3'b000: op = (alu_op == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b101: op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_hazard.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution with
// IF/ID redirect, and the EX/MEM pipeline register.
module ex_hazard
  import rv_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC_TARGET = '0
) (
  input logic      clk,
  input logic      rst_n,
  ex_hazard_if.slave bus
);

  logic [4:0]      rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      opcode;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_in2, alu_out, ex_result;
  logic [XLEN-1:0] pc_imm, jalr_sum, redirect_target;
  logic            taken, pc_sel;
  logic            unused_instr_bits;

  assign rs1    = bus.instruc_IDEX[19:15];
  assign rs2    = bus.instruc_IDEX[24:20];
  assign funct3 = bus.instruc_IDEX[14:12];
  assign opcode = bus.instruc_IDEX[6:0];
  assign unused_instr_bits = ^{bus.instruc_IDEX[31], bus.instruc_IDEX[29:25],
                               bus.instruc_IDEX[11:7]};

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards
  always_comb begin
    fwd_a = bus.read_data1_IDEX;
    if (bus.RegWrite_EXMEM_fb && bus.rd_EXMEM_fb != 5'd0 && bus.rd_EXMEM_fb == rs1)
      fwd_a = bus.alu_result_EXMEM_fb;
    else if (bus.RegWrite && bus.rd != 5'd0 && bus.rd == rs1)
      fwd_a = bus.write_Data;
  end

  always_comb begin
    fwd_b = bus.read_data2_IDEX;
    if (bus.RegWrite_EXMEM_fb && bus.rd_EXMEM_fb != 5'd0 && bus.rd_EXMEM_fb == rs2)
      fwd_b = bus.alu_result_EXMEM_fb;
    else if (bus.RegWrite && bus.rd != 5'd0 && bus.rd == rs2)
      fwd_b = bus.write_Data;
  end

  assign alu_in2 = bus.ALUSrc_IDEX ? bus.imm_IDEX : fwd_b;

  alu_control_alu #(.XLEN(XLEN)) u_alu (
    .alu_op   (bus.ALUOp_IDEX),
    .funct3   (funct3),
    .funct7_5 (bus.instruc_IDEX[30]),
    .a        (fwd_a),
    .b        (alu_in2),
    .result   (alu_out)
  );

  assign pc_imm   = bus.PC_IDEX + bus.imm_IDEX;
  assign jalr_sum = fwd_a + bus.imm_IDEX;

  // jumps write the link address through the ALU path so forwarding sees it
  always_comb begin
    ex_result = alu_out;
    if (bus.jump_IDEX)          ex_result = bus.PC_plus4_IDEX;
    else if (opcode == OP_LUI)   ex_result = bus.imm_IDEX;
    else if (opcode == OP_AUIPC) ex_result = pc_imm;
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a <  fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign redirect_target = (opcode == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;
  assign pc_sel          = bus.jump_IDEX | (bus.branch_IDEX & taken);
  assign bus.pc_sel      = pc_sel;
  assign bus.flush_IF    = pc_sel;
  assign bus.flush_ID    = pc_sel;
  assign bus.pc_target   = pc_sel ? redirect_target : RESET_PC_TARGET;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_result_EXMEM <= '0;
      bus.store_data_EXMEM <= '0;
      bus.PC_plus4_EXMEM   <= '0;
      bus.rd_EXMEM         <= '0;
      bus.funct3_EXMEM     <= '0;
      bus.memRead_EXMEM    <= 1'b0;
      bus.memWrite_EXMEM   <= 1'b0;
      bus.RegWrite_EXMEM   <= 1'b0;
      bus.mem2reg_EXMEM    <= M2R_ALU;
    end else begin
      bus.alu_result_EXMEM <= ex_result;
      bus.store_data_EXMEM <= fwd_b;
      bus.PC_plus4_EXMEM   <= bus.PC_plus4_IDEX;
      bus.rd_EXMEM         <= bus.rd_IDEX;
      bus.funct3_EXMEM     <= funct3;
      bus.memRead_EXMEM    <= bus.memRead_IDEX;
      bus.memWrite_EXMEM   <= bus.memWrite_IDEX;
      bus.RegWrite_EXMEM   <= bus.RegWrite_IDEX;
      bus.mem2reg_EXMEM    <= bus.mem2reg_IDEX;
    end
  end

endmodule

// File: tb/tb_ex_hazard.sv
// Directed bench for ex_hazard: forwarding, ALU decode, branch/jump redirect
// and asynchronous reset of the EX/MEM register.
module tb_ex_hazard;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_hazard_if #(.XLEN(32)) ex_if ();

  ex_hazard #(.XLEN(32), .RESET_PC_TARGET(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ex_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rdst, input logic [6:0] op);
    return {f7, r2, r1, f3, rdst, op};
  endfunction

  task automatic clear_inputs();
    ex_if.read_data1_IDEX = '0; ex_if.read_data2_IDEX = '0;
    ex_if.PC_IDEX = '0; ex_if.PC_plus4_IDEX = '0; ex_if.imm_IDEX = '0;
    ex_if.instruc_IDEX = '0; ex_if.rd_IDEX = '0;
    ex_if.branch_IDEX = 0; ex_if.memRead_IDEX = 0; ex_if.memWrite_IDEX = 0;
    ex_if.ALUSrc_IDEX = 0; ex_if.RegWrite_IDEX = 0; ex_if.jump_IDEX = 0;
    ex_if.mem2reg_IDEX = '0; ex_if.ALUOp_IDEX = '0;
    ex_if.alu_result_EXMEM_fb = '0; ex_if.rd_EXMEM_fb = '0; ex_if.RegWrite_EXMEM_fb = 0;
    ex_if.write_Data = '0; ex_if.rd = '0; ex_if.RegWrite = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'h0 || ex_if.RegWrite_EXMEM !== 1'b0 || ex_if.rd_EXMEM !== 5'd0) begin
      errors++;
      $display("FAIL reset_exmem got alu=%h rw=%b rd=%0d exp 0", ex_if.alu_result_EXMEM, ex_if.RegWrite_EXMEM, ex_if.rd_EXMEM);
    end
    checks++;
    if (ex_if.pc_sel !== 1'b0 || ex_if.flush_IF !== 1'b0 || ex_if.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_redirect got sel=%b flush=%b tgt=%h exp 0/0/0", ex_if.pc_sel, ex_if.flush_IF, ex_if.pc_target);
    end
    $display("reset: alu=%h pc_sel=%b", ex_if.alu_result_EXMEM, ex_if.pc_sel);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_add();
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    ex_if.read_data1_IDEX = 32'd7; ex_if.read_data2_IDEX = -32'sd3;
    ex_if.ALUOp_IDEX = 2'b10; ex_if.RegWrite_IDEX = 1; ex_if.rd_IDEX = 5'd3;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'd4) begin
      errors++; $display("FAIL add_result got %h exp %h", ex_if.alu_result_EXMEM, 32'd4);
    end
    checks++;
    if (ex_if.RegWrite_EXMEM !== 1'b1 || ex_if.rd_EXMEM !== 5'd3) begin
      errors++; $display("FAIL add_ctrl got rw=%b rd=%0d exp rw=1 rd=3", ex_if.RegWrite_EXMEM, ex_if.rd_EXMEM);
    end
    $display("add 7+-3: result=%h", ex_if.alu_result_EXMEM);
  endtask

  task automatic test_forwarding();
    // ADDI x6, x5, 1 with both stages writing x5
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0010011);
    ex_if.imm_IDEX = 32'd1; ex_if.ALUSrc_IDEX = 1; ex_if.ALUOp_IDEX = 2'b11;
    ex_if.read_data1_IDEX = 32'd7; ex_if.RegWrite_IDEX = 1; ex_if.rd_IDEX = 5'd6;
    ex_if.RegWrite_EXMEM_fb = 1; ex_if.rd_EXMEM_fb = 5'd5; ex_if.alu_result_EXMEM_fb = 32'd100;
    ex_if.RegWrite = 1; ex_if.rd = 5'd5; ex_if.write_Data = 32'd50;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'd101) begin
      errors++; $display("FAIL fwd_exmem_priority got %0d exp 101", ex_if.alu_result_EXMEM);
    end
    $display("fwd exmem+memwb: result=%0d", ex_if.alu_result_EXMEM);
    ex_if.RegWrite_EXMEM_fb = 0;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'd51) begin
      errors++; $display("FAIL fwd_memwb got %0d exp 51", ex_if.alu_result_EXMEM);
    end
    $display("fwd memwb only: result=%0d", ex_if.alu_result_EXMEM);
    // rs1 = x0 with both stages claiming x0
    ex_if.instruc_IDEX = mk(7'b0, 5'd1, 5'd0, 3'b000, 5'd6, 7'b0010011);
    ex_if.read_data1_IDEX = 32'd0;
    ex_if.RegWrite_EXMEM_fb = 1; ex_if.rd_EXMEM_fb = 5'd0; ex_if.rd = 5'd0;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'd1) begin
      errors++; $display("FAIL fwd_x0 got %0d exp 1", ex_if.alu_result_EXMEM);
    end
    $display("fwd x0: result=%0d", ex_if.alu_result_EXMEM);
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011);
    ex_if.read_data1_IDEX = 32'd9; ex_if.read_data2_IDEX = 32'd9;
    ex_if.branch_IDEX = 1; ex_if.ALUOp_IDEX = 2'b01;
    ex_if.PC_IDEX = 32'h100; ex_if.imm_IDEX = 32'h20;
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b0 || ex_if.flush_ID !== 1'b0 || ex_if.pc_target !== 32'h0) begin
      errors++; $display("FAIL bne_equal got sel=%b flush=%b tgt=%h exp 0/0/0", ex_if.pc_sel, ex_if.flush_ID, ex_if.pc_target);
    end
    $display("bne 9,9: pc_sel=%b", ex_if.pc_sel);
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011);
    ex_if.read_data1_IDEX = 32'hFFFF_FFFF; ex_if.read_data2_IDEX = 32'd1;
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b1 || ex_if.flush_IF !== 1'b1 || ex_if.flush_ID !== 1'b1 || ex_if.pc_target !== 32'h120) begin
      errors++; $display("FAIL blt_taken got sel=%b fi=%b fd=%b tgt=%h exp 1/1/1/120", ex_if.pc_sel, ex_if.flush_IF, ex_if.flush_ID, ex_if.pc_target);
    end
    $display("blt -1,1: pc_sel=%b target=%h", ex_if.pc_sel, ex_if.pc_target);
    // BLTU -1 vs 1 is not taken
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011);
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b0) begin
      errors++; $display("FAIL bltu_unsigned got %b exp 0", ex_if.pc_sel);
    end
    $display("bltu -1,1: pc_sel=%b", ex_if.pc_sel);
    // BEQ decided on the forwarded rs1 value
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011);
    ex_if.read_data1_IDEX = 32'd3; ex_if.read_data2_IDEX = 32'd9;
    ex_if.RegWrite_EXMEM_fb = 1; ex_if.rd_EXMEM_fb = 5'd1; ex_if.alu_result_EXMEM_fb = 32'd9;
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b1 || ex_if.pc_target !== 32'h120) begin
      errors++; $display("FAIL beq_forwarded got sel=%b tgt=%h exp 1/120", ex_if.pc_sel, ex_if.pc_target);
    end
    $display("beq fwd 9,9: pc_sel=%b", ex_if.pc_sel);
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011);
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b0) begin
      errors++; $display("FAIL branch_f3_010 got %b exp 0", ex_if.pc_sel);
    end
    $display("branch f3=010: pc_sel=%b", ex_if.pc_sel);
    @(posedge clk); #1;
  endtask

  task automatic test_jalr();
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd4, 5'd1, 3'b000, 5'd1, 7'b1100111);
    ex_if.read_data1_IDEX = 32'h1003; ex_if.imm_IDEX = 32'd4;
    ex_if.PC_IDEX = 32'h200; ex_if.PC_plus4_IDEX = 32'h204;
    ex_if.jump_IDEX = 1; ex_if.ALUSrc_IDEX = 1; ex_if.RegWrite_IDEX = 1;
    ex_if.rd_IDEX = 5'd1; ex_if.mem2reg_IDEX = 2'b10;
    #1;
    checks++;
    if (ex_if.pc_sel !== 1'b1 || ex_if.pc_target !== 32'h1006) begin
      errors++; $display("FAIL jalr_target got sel=%b tgt=%h exp 1/1006", ex_if.pc_sel, ex_if.pc_target);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'h204 || ex_if.mem2reg_EXMEM !== 2'b10 || ex_if.PC_plus4_EXMEM !== 32'h204) begin
      errors++; $display("FAIL jalr_link got alu=%h m2r=%b pc4=%h exp 204/10/204", ex_if.alu_result_EXMEM, ex_if.mem2reg_EXMEM, ex_if.PC_plus4_EXMEM);
    end
    $display("jalr: target=1006 link=%h", ex_if.alu_result_EXMEM);
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_res [7];
    logic [31:0] ins [7];
    logic [31:0] a_val [7];
    logic [31:0] b_val [7];
    logic [1:0]  aop [7];
    logic        src [7];
    // SRA, SRL, SRAI, SLTU, SLT, ADDI with bit30 set, LUI
    ins[0] = mk(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011); aop[0] = 2'b10; src[0] = 0;
    a_val[0] = 32'h8000_0000; b_val[0] = 32'd4; exp_res[0] = 32'hF800_0000;
    ins[1] = mk(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011); aop[1] = 2'b10; src[1] = 0;
    a_val[1] = 32'h8000_0000; b_val[1] = 32'd4; exp_res[1] = 32'h0800_0000;
    ins[2] = mk(7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011); aop[2] = 2'b11; src[2] = 1;
    a_val[2] = 32'h8000_0000; b_val[2] = 32'h404; exp_res[2] = 32'hF800_0000;
    ins[3] = mk(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011); aop[3] = 2'b10; src[3] = 0;
    a_val[3] = 32'hFFFF_FFFF; b_val[3] = 32'd1; exp_res[3] = 32'd0;
    ins[4] = mk(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011); aop[4] = 2'b10; src[4] = 0;
    a_val[4] = 32'hFFFF_FFFF; b_val[4] = 32'd1; exp_res[4] = 32'd1;
    ins[5] = mk(7'b1100000, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0010011); aop[5] = 2'b11; src[5] = 1;
    a_val[5] = 32'd2000; b_val[5] = 32'hFFFF_FC00; exp_res[5] = 32'd976;
    ins[6] = mk(7'b0001001, 5'd3, 5'd4, 3'b101, 5'd3, 7'b0110111); aop[6] = 2'b00; src[6] = 1;
    a_val[6] = 32'd55; b_val[6] = 32'h1234_5000; exp_res[6] = 32'h1234_5000;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      ex_if.instruc_IDEX = ins[i]; ex_if.ALUOp_IDEX = aop[i]; ex_if.ALUSrc_IDEX = src[i];
      ex_if.read_data1_IDEX = a_val[i];
      if (src[i]) ex_if.imm_IDEX = b_val[i];
      else        ex_if.read_data2_IDEX = b_val[i];
      ex_if.RegWrite_IDEX = 1; ex_if.rd_IDEX = 5'd3;
      @(posedge clk); #1;
      checks++;
      if (ex_if.alu_result_EXMEM !== exp_res[i]) begin
        errors++; $display("FAIL alu_op_%0d got %h exp %h", i, ex_if.alu_result_EXMEM, exp_res[i]);
      end
      $display("alu vector %0d: a=%h b=%h result=%h", i, a_val[i], b_val[i], ex_if.alu_result_EXMEM);
    end
    // AUIPC
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd0, 3'b000, 5'd3, 7'b0010111);
    ex_if.PC_IDEX = 32'h1000; ex_if.imm_IDEX = 32'h2000; ex_if.ALUSrc_IDEX = 1;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'h3000) begin
      errors++; $display("FAIL auipc got %h exp %h", ex_if.alu_result_EXMEM, 32'h3000);
    end
    $display("auipc: result=%h", ex_if.alu_result_EXMEM);
  endtask

  task automatic test_async_reset();
    // SW x2, 8(x1)
    clear_inputs();
    ex_if.instruc_IDEX = mk(7'b0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011);
    ex_if.read_data1_IDEX = 32'h1000; ex_if.read_data2_IDEX = 32'hDEAD_BEEF;
    ex_if.imm_IDEX = 32'd8; ex_if.ALUSrc_IDEX = 1; ex_if.memWrite_IDEX = 1;
    ex_if.PC_plus4_IDEX = 32'h44;
    @(posedge clk); #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'h1008 || ex_if.store_data_EXMEM !== 32'hDEAD_BEEF ||
        ex_if.memWrite_EXMEM !== 1'b1 || ex_if.funct3_EXMEM !== 3'b010) begin
      errors++; $display("FAIL store_inflight got addr=%h data=%h mw=%b f3=%b exp 1008/deadbeef/1/010",
                         ex_if.alu_result_EXMEM, ex_if.store_data_EXMEM, ex_if.memWrite_EXMEM, ex_if.funct3_EXMEM);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_if.alu_result_EXMEM !== 32'h0 || ex_if.store_data_EXMEM !== 32'h0 || ex_if.PC_plus4_EXMEM !== 32'h0 ||
        ex_if.memWrite_EXMEM !== 1'b0 || ex_if.funct3_EXMEM !== 3'b0 || ex_if.rd_EXMEM !== 5'd0) begin
      errors++; $display("FAIL async_reset got addr=%h data=%h pc4=%h mw=%b f3=%b rd=%0d exp all 0",
                         ex_if.alu_result_EXMEM, ex_if.store_data_EXMEM, ex_if.PC_plus4_EXMEM,
                         ex_if.memWrite_EXMEM, ex_if.funct3_EXMEM, ex_if.rd_EXMEM);
    end
    $display("async reset mid-store: addr=%h data=%h", ex_if.alu_result_EXMEM, ex_if.store_data_EXMEM);
    clear_inputs();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ex_if.alu_result_EXMEM !== 32'h0 || ex_if.memWrite_EXMEM !== 1'b0 || ex_if.RegWrite_EXMEM !== 1'b0 ||
          ex_if.memRead_EXMEM !== 1'b0 || ex_if.mem2reg_EXMEM !== 2'b00) begin
        errors++; $display("FAIL bubble_%0d got alu=%h mw=%b rw=%b mr=%b m2r=%b exp all 0", c,
                           ex_if.alu_result_EXMEM, ex_if.memWrite_EXMEM, ex_if.RegWrite_EXMEM,
                           ex_if.memRead_EXMEM, ex_if.mem2reg_EXMEM);
      end
      $display("bubble %0d: alu=%h", c, ex_if.alu_result_EXMEM);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rtype_add();
    test_forwarding();
    test_branch();
    test_jalr();
    test_alu_ops();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_hazard.md
Name: ex_hazard

Overview:
- Execute stage of the 5-stage RV32I hazard pipeline; consumer (reader) of the ID/EX register.
- Forwards operands from EX/MEM and MEM/WB, decodes ALU control, and computes the ALU result.
- Resolves branches and jumps, and drives the redirect/flush signals back to IF/ID.
- Registers everything into the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_TARGET, 32'h0, pc_target value while no redirect is active.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- read_data1_IDEX, read_data2_IDEX  in  32  register operands (signed)
- PC_IDEX, PC_plus4_IDEX, imm_IDEX  in  32  PC, PC+4, sign-extended immediate
- instruc_IDEX  in  32  full instruction (rs1 [19:15], rs2 [24:20], funct3 [14:12], funct7[5] = bit 30, opcode [6:0])
- rd_IDEX  in  5  destination register
- branch_IDEX, memRead_IDEX, memWrite_IDEX, ALUSrc_IDEX, RegWrite_IDEX, jump_IDEX  in  1  control signals
- mem2reg_IDEX  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- ALUOp_IDEX  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type
- alu_result_EXMEM_fb  in  32  EX/MEM result (forward source)
- rd_EXMEM_fb  in  5  EX/MEM destination (forward source)
- RegWrite_EXMEM_fb  in  1  EX/MEM write enable (forward source)
- write_Data  in  32  MEM/WB writeback value
- rd  in  5  MEM/WB destination
- RegWrite  in  1  MEM/WB write enable
- pc_sel  out  1  redirect fetch (combinational)
- pc_target  out  32  redirect address (combinational)
- flush_IF, flush_ID  out  1  squash IF/ID and ID/EX (combinational, equal to pc_sel)
- alu_result_EXMEM, store_data_EXMEM, PC_plus4_EXMEM  out  32  registered
- rd_EXMEM  out  5  registered
- funct3_EXMEM  out  3  registered
- memRead_EXMEM, memWrite_EXMEM, RegWrite_EXMEM  out  1  registered
- mem2reg_EXMEM  out  2  registered

Behaviour:
- Reset (rst_n low, async): every EX/MEM output goes to 0. The combinational outputs follow from the zeroed ID/EX inputs: pc_sel = 0, flush = 0, pc_target = RESET_PC_TARGET.
- Forwarding, per operand (rs1 -> A, rs2 -> B):
  - If RegWrite_EXMEM_fb and rd_EXMEM_fb != 0 and rd_EXMEM_fb == rs, take alu_result_EXMEM_fb.
  - Else if RegWrite and rd != 0 and rd == rs, take write_Data.
  - Else take the ID/EX value.
  - EX/MEM has priority; x0 is never forwarded.
- ALU input 2: imm_IDEX when ALUSrc_IDEX, otherwise forwarded B. store_data is always forwarded B.
- ALU control:
  - ALUOp 00 -> ADD.
  - 01 -> SUB.
  - 10 -> decode funct3 plus bit 30: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - 11 -> same decode, but bit 30 only selects SRA for funct3 101; there is no SUBI.
  - Shift amount is [4:0]. SLT is signed; SLTU is unsigned. Results wrap mod 2^32.
- LUI (opcode 0110111): result = imm. AUIPC (0010111): result = PC + imm.
- Jumps: result = PC_plus4_IDEX, so forwarding stays uniform.
  - JAL target = PC + imm.
  - JALR (opcode 1100111) target = (forwarded A + imm) & ~1.
- Branch condition on forwarded A/B by funct3:
  - BEQ 000, BNE 001, BLT 100, BGE 101 (signed).
  - BLTU 110, BGEU 111 (unsigned).
  - Funct3 010/011 never taken.
  - Target = PC + imm.
- pc_sel = jump_IDEX | (branch_IDEX & taken). flush_IF = flush_ID = pc_sel, asserted in the same cycle. The instruction in EX itself still advances to EX/MEM.
- Latency: one cycle, ID/EX to EX/MEM. There is no stall input; load-use bubbles arrive as all-zero ID/EX control, which propagates as a NOP.
- Simultaneous events: a redirect and a forward in the same cycle both apply; the branch uses the forwarded operands.
- Reset mid-operation clears EX/MEM immediately, without waiting for a clock edge.

Decomposition:
- Shared package (rv_pkg):
  - ALUOp codes, ALU operation enum.
  - mem2reg codes, opcode constants.
  - Branch funct3 constants.
- One natural sub-module: alu_control_alu (ALU decode plus arithmetic, combinational). Forwarding, branch logic and the register stay in ex_hazard.

Test Plan:
- R-type ADD, A = 7, B = -3, no hazards -> alu_result_EXMEM = 4 next cycle; RegWrite_EXMEM = 1.
- EX/MEM writes x5 = 100 and MEM/WB writes x5 = 50; EX consumes rs1 = x5 in ADDI +1 -> result 101 (EX/MEM priority). Repeat with rd = 0 -> no forward.
- BNE with A = B = 9 -> pc_sel = 0. BLT with A = -1, B = 1 -> pc_sel = 1, flush_IF = flush_ID = 1, pc_target = PC + imm.
- JALR with A = 0x1003, imm = 4 -> pc_target = 0x1006; alu_result_EXMEM = PC + 4.
- Inputs SRA and SRL of 0x80000000 by 4 -> results 0xF8000000 and 0x08000000. SLTU of -1 vs 1 -> 0.
- rst_n pulled low mid-cycle while a store is in flight -> all EX/MEM outputs are 0 immediately. After release, a zero-control bubble input keeps them 0.
